zbt_point_arbiter: RTL and testbench

- Shares the single ZBT0 SRAM port between two requesters: the point writer (scanner capture path storing packed {x[29:20], y[19:10], z[9:0]} words) and the point reader (renderer sweep).
- Issues at most one ZBT transaction per cycle, chosen round-robin.
- Aligns write data to the ZBT write pipeline and returns read data with a valid strobe.
- Tracks the number of stored points, so the renderer knows how far to sweep.

---
 rtl/zbt_pkg.sv | 38 +++
 rtl/zbt_delay_line.sv | 29 ++
 rtl/zbt_point_arbiter.sv | 150 +++++++++++++++
 tb/tb_zbt_point_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zbt_pkg.sv
// Shared ZBT0 widths, packed point word layout and arbiter grant encoding.
package zbt_pkg;

  localparam int unsigned ZBT_ADDR_W = 19;
  localparam int unsigned ZBT_DATA_W = 36;

  localparam int unsigned X_MSB = 29;
  localparam int unsigned X_LSB = 20;
  localparam int unsigned Y_MSB = 19;
  localparam int unsigned Y_LSB = 10;
  localparam int unsigned Z_MSB = 9;
  localparam int unsigned Z_LSB = 0;

  typedef enum logic {
    GRANT_READ  = 1'b0,
    GRANT_WRITE = 1'b1
  } grant_t;

  typedef struct packed {
    logic [ZBT_DATA_W-X_MSB-2:0] rsvd;
    logic [X_MSB-X_LSB:0]        x;
    logic [Y_MSB-Y_LSB:0]        y;
    logic [Z_MSB-Z_LSB:0]        z;
  } point_t;

  // Builds a point word with the unused upper bits cleared.
  function automatic point_t pack_point(input logic [X_MSB-X_LSB:0] x,
                                        input logic [Y_MSB-Y_LSB:0] y,
                                        input logic [Z_MSB-Z_LSB:0] z);
    point_t p;
    p      = '0;
    p.x    = x;
    p.y    = y;
    p.z    = z;
    return p;
  endfunction

endpackage

// File: rtl/zbt_delay_line.sv
// Fixed-depth shift register with asynchronous clear; output lags input by DEPTH edges.
module zbt_delay_line #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= din_i;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign dout_o = stage_q[DEPTH-1];

endmodule

// File: rtl/zbt_point_arbiter.sv
// Round-robin sharing of the ZBT0 port between the point writer and point reader,
// with write-data alignment, read-data return and stored point tracking.
module zbt_point_arbiter
  import zbt_pkg::*;
#(
  parameter int unsigned ADDR_W    = ZBT_ADDR_W,
  parameter int unsigned DATA_W    = ZBT_DATA_W,
  parameter int unsigned READ_LAT  = 2,
  parameter int unsigned WRITE_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ack,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              clear_points,
  output logic [ADDR_W:0]   point_count,
  output logic [ADDR_W-1:0] zbt_addr,
  output logic              zbt_we,
  output logic [DATA_W-1:0] zbt_write_data,
  input  logic [DATA_W-1:0] zbt_read_data
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  grant_t            last_q, last_d;
  logic              wr_gnt_c, rd_gnt_c;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic              rd_issue_q, rd_issue_d;

  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_base_c, wr_top_c;

  logic [DATA_W-1:0] wdata_in_c, wdata_dly;
  logic              wvalid_dly, rvalid_dly;

  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q <= GRANT_READ;
    end else begin
      last_q <= last_d;
    end
  end

  // A lone requester wins; on contention the side not granted last wins.
  always_comb begin
    last_d   = last_q;
    wr_gnt_c = 1'b0;
    rd_gnt_c = 1'b0;
    if (wr_req && (!rd_req || (last_q == GRANT_READ))) begin
      wr_gnt_c = 1'b1;
      last_d   = GRANT_WRITE;
    end else if (rd_req) begin
      rd_gnt_c = 1'b1;
      last_d   = GRANT_READ;
    end
  end

  assign wr_ack = wr_gnt_c;
  assign rd_ack = rd_gnt_c;

  always_comb begin
    addr_d     = addr_q;
    we_d       = wr_gnt_c;
    rd_issue_d = rd_gnt_c;
    if (wr_gnt_c) begin
      addr_d = wr_addr;
    end else if (rd_gnt_c) begin
      addr_d = rd_addr;
    end
  end

  // Clear takes effect before a same-cycle write raises the count.
  always_comb begin
    cnt_base_c = clear_points ? '0 : cnt_q;
    wr_top_c   = CNT_W'(wr_addr) + CNT_W'(1);
    cnt_d      = cnt_base_c;
    if (wr_gnt_c && (wr_top_c > cnt_base_c)) begin
      cnt_d = wr_top_c;
    end
  end

  assign wdata_in_c = wr_gnt_c ? wr_data : '0;

  zbt_delay_line #(.WIDTH(DATA_W), .DEPTH(WRITE_LAT)) u_wdata_dly (
    .clk    (clk),
    .reset  (reset),
    .din_i  (wdata_in_c),
    .dout_o (wdata_dly)
  );

  zbt_delay_line #(.WIDTH(1), .DEPTH(WRITE_LAT)) u_wvalid_dly (
    .clk    (clk),
    .reset  (reset),
    .din_i  (wr_gnt_c),
    .dout_o (wvalid_dly)
  );

  zbt_delay_line #(.WIDTH(1), .DEPTH(READ_LAT)) u_rvalid_dly (
    .clk    (clk),
    .reset  (reset),
    .din_i  (rd_issue_q),
    .dout_o (rvalid_dly)
  );

  // Write data holds its slot value until the next write arrives.
  always_comb begin
    wdata_d = wvalid_dly ? wdata_dly : wdata_q;
    rdata_d = rvalid_dly ? zbt_read_data : rdata_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q     <= '0;
      we_q       <= 1'b0;
      rd_issue_q <= 1'b0;
      cnt_q      <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      we_q       <= we_d;
      rd_issue_q <= rd_issue_d;
      cnt_q      <= cnt_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_dly;
    end
  end

  assign zbt_addr       = addr_q;
  assign zbt_we         = we_q;
  assign zbt_write_data = wdata_q;
  assign rd_data        = rdata_q;
  assign rd_valid       = rvalid_q;
  assign point_count    = cnt_q;

endmodule

// File: tb/tb_zbt_point_arbiter.sv
// Directed and random checks of zbt_point_arbiter against a queue-based reference model
// and a bus-level ZBT SRAM model.
module tb_zbt_point_arbiter;
  import zbt_pkg::*;

  localparam int unsigned AW = 19;
  localparam int unsigned DW = 36;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned RL = 2;
  localparam int unsigned WL = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ack;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_ack;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          clear_points;
  logic [AW:0]   point_count;
  logic [AW-1:0] zbt_addr;
  logic          zbt_we;
  logic [DW-1:0] zbt_write_data;
  logic [DW-1:0] zbt_read_data;

  always #5 clk = ~clk;

  zbt_point_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .READ_LAT(RL), .WRITE_LAT(WL)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .wr_req         (wr_req),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .wr_ack         (wr_ack),
    .rd_req         (rd_req),
    .rd_addr        (rd_addr),
    .rd_ack         (rd_ack),
    .rd_data        (rd_data),
    .rd_valid       (rd_valid),
    .clear_points   (clear_points),
    .point_count    (point_count),
    .zbt_addr       (zbt_addr),
    .zbt_we         (zbt_we),
    .zbt_write_data (zbt_write_data),
    .zbt_read_data  (zbt_read_data)
  );

  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } ev_t;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n_valid = 0;
  bit got_w, got_r;
  bit writer_last;

  logic [DW-1:0] ref_mem [int];
  logic [DW-1:0] sram [int];
  ev_t           wq [$];
  ev_t           rq [$];

  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;
  logic [AW:0]   m_cnt;

  bit            h_ok [8];
  bit            h_we [8];
  logic [AW-1:0] h_addr [8];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  // One clock cycle: check outputs against the model, run the SRAM model, advance.
  task automatic step();
    bit            ew, er, m_rv;
    int            j, k, top, nxt_cnt;
    logic          nxt_we;
    logic [AW-1:0] nxt_addr;
    #1;
    if (reset) begin
      m_we = 1'b0; m_addr = '0; m_wdata = '0; m_rdata = '0; m_cnt = '0;
      writer_last = 1'b0;
      wq.delete();
      rq.delete();
      for (int i = 0; i < 8; i++) h_ok[i] = 1'b0;
    end
    m_rv = 1'b0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      m_rv = 1'b1;
      m_rdata = rq[0].data;
      rq.delete(0);
    end
    if (wq.size() > 0 && wq[0].due == cyc) begin
      m_wdata = wq[0].data;
      wq.delete(0);
    end
    check("zbt_we", 64'(zbt_we), 64'(m_we));
    check("zbt_addr", 64'(zbt_addr), 64'(m_addr));
    check("zbt_write_data", 64'(zbt_write_data), 64'(m_wdata));
    check("rd_valid", 64'(rd_valid), 64'(m_rv));
    check("rd_data", 64'(rd_data), 64'(m_rdata));
    check("point_count", 64'(point_count), 64'(m_cnt));
    if (rd_valid === 1'b1) n_valid++;

    ew = wr_req && (!rd_req || !writer_last);
    er = rd_req && !ew;
    got_w = wr_ack;
    got_r = rd_ack;
    check("acks", 64'({wr_ack, rd_ack}), 64'({ew, er}));

    nxt_we   = 1'b0;
    nxt_addr = m_addr;
    nxt_cnt  = clear_points ? 0 : int'(m_cnt);
    if (reset) begin
      nxt_cnt = 0;
    end else if (ew) begin
      nxt_we   = 1'b1;
      nxt_addr = wr_addr;
      ref_mem[int'(wr_addr)] = wr_data;
      wq.push_back('{due: cyc + 1 + int'(WL), data: wr_data});
      writer_last = 1'b1;
      top = int'(wr_addr) + 1;
      if (top > nxt_cnt) nxt_cnt = top;
    end else if (er) begin
      nxt_addr = rd_addr;
      rq.push_back('{due: cyc + 2 + int'(RL),
                     data: ref_mem.exists(int'(rd_addr)) ? ref_mem[int'(rd_addr)] : '0});
      writer_last = 1'b0;
    end

    // ZBT device: write data taken WL cycles after its address, read data driven RL after.
    h_ok[cyc % 8]   = !reset;
    h_we[cyc % 8]   = zbt_we;
    h_addr[cyc % 8] = zbt_addr;
    j = (cyc + 8 - int'(WL)) % 8;
    k = (cyc + 8 - int'(RL)) % 8;
    if (h_ok[j] && h_we[j]) sram[int'(h_addr[j])] = zbt_write_data;
    if (h_ok[k] && !h_we[k])
      zbt_read_data = sram.exists(int'(h_addr[k])) ? sram[int'(h_addr[k])] : '0;
    else
      zbt_read_data = DW'({$urandom(), $urandom()});

    @(posedge clk);
    #1;
    cyc++;
    m_we   = nxt_we;
    m_addr = nxt_addr;
    m_cnt  = CW'(nxt_cnt);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit done;
    done = 1'b0;
    wr_req = 1'b1; wr_addr = a; wr_data = d;
    for (int i = 0; i < 20 && !done; i++) begin
      step();
      done = got_w;
    end
    wr_req = 1'b0;
    check("write_granted", 64'(done), 64'd1);
  endtask

  task automatic do_read(input logic [AW-1:0] a);
    bit done;
    done = 1'b0;
    rd_req = 1'b1; rd_addr = a;
    for (int i = 0; i < 20 && !done; i++) begin
      step();
      done = got_r;
    end
    rd_req = 1'b0;
    check("read_granted", 64'(done), 64'd1);
  endtask

  initial begin
    logic [5:0]    seq;
    logic [DW-1:0] wd;
    int            n0;

    reset = 1'b1; wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    rd_req = 1'b0; rd_addr = '0; clear_points = 1'b0; zbt_read_data = '0;
    repeat (3) step();
    reset = 1'b0;
    repeat (5) step();

    // Contention straight out of reset: writer takes the first tie.
    wr_req = 1'b1; wr_addr = AW'(32'h100); wr_data = pack_point(10'd1, 10'd2, 10'd3);
    rd_req = 1'b1; rd_addr = AW'(32'h200);
    seq = '0;
    for (int i = 0; i < 6; i++) begin
      step();
      seq = {seq[4:0], got_w};
      check("one_ack", 64'(got_w ^ got_r), 64'd1);
    end
    wr_req = 1'b0; rd_req = 1'b0;
    check("contention_seq", 64'(seq), 64'(6'b101010));
    repeat (6) step();

    // Single write and read-back.
    clear_points = 1'b1; step(); clear_points = 1'b0;
    wd = 36'h012345678;
    do_write(AW'(32'h5), wd);
    check("w5_we", 64'(zbt_we), 64'd1);
    check("w5_addr", 64'(zbt_addr), 64'h5);
    check("w5_count", 64'(point_count), 64'd6);
    repeat (2) step();
    check("w5_wdata", 64'(zbt_write_data), 64'h012345678);
    repeat (2) step();
    do_read(AW'(32'h5));
    check("r5_early", 64'(rd_valid), 64'd0);
    repeat (3) step();
    check("r5_valid", 64'(rd_valid), 64'd1);
    check("r5_data", 64'(rd_data), 64'(wd));
    repeat (2) step();

    // Preload 0..7 then stream them back.
    for (int a = 0; a < 8; a++)
      do_write(AW'(a), pack_point(10'($urandom), 10'($urandom), 10'($urandom)));
    repeat (4) step();
    n0 = n_valid;
    rd_req = 1'b1; rd_addr = '0;
    for (int i = 0; i < 40 && rd_req; i++) begin
      step();
      if (got_r) begin
        if (rd_addr == AW'(7)) rd_req = 1'b0;
        else rd_addr = rd_addr + AW'(1);
      end
    end
    rd_req = 1'b0;
    repeat (6) step();
    check("stream_valids", 64'(n_valid - n0), 64'd8);

    // point_count rules.
    clear_points = 1'b1; step(); clear_points = 1'b0;
    check("cnt_clear0", 64'(point_count), 64'd0);
    do_write(AW'(32'd10), 36'h1);
    do_write(AW'(32'd3), 36'h2);
    check("cnt_11", 64'(point_count), 64'd11);
    clear_points = 1'b1; step(); clear_points = 1'b0;
    check("cnt_clear", 64'(point_count), 64'd0);
    do_write(AW'(32'd10), 36'h3);
    clear_points = 1'b1; wr_req = 1'b1; wr_addr = AW'(32'd7); wr_data = 36'h4;
    step();
    clear_points = 1'b0; wr_req = 1'b0;
    check("clr_wr_granted", 64'(got_w), 64'd1);
    check("cnt_8", 64'(point_count), 64'd8);
    do_write(AW'(32'h7FFFF), 36'h5);
    check("cnt_max", 64'(point_count), 64'h80000);
    repeat (4) step();

    // Random traffic from two well-behaved requesters.
    for (int i = 0; i < 300; i++) begin
      if (!wr_req && $urandom_range(0, 2) == 0) begin
        wr_req = 1'b1; wr_addr = AW'($urandom_range(0, 15));
        wr_data = pack_point(10'($urandom), 10'($urandom), 10'($urandom));
      end
      if (!rd_req && $urandom_range(0, 1) == 0) begin
        rd_req = 1'b1; rd_addr = AW'($urandom_range(0, 15));
      end
      clear_points = ($urandom_range(0, 19) == 0);
      step();
      if (got_w) wr_req = 1'b0;
      if (got_r) rd_req = 1'b0;
    end
    wr_req = 1'b0; rd_req = 1'b0; clear_points = 1'b0;
    repeat (6) step();

    // Asynchronous reset with a write in flight.
    do_write(AW'(32'h9), 36'hABCDE1234);
    reset = 1'b1;
    #1;
    check("async_we", 64'(zbt_we), 64'd0);
    check("async_addr", 64'(zbt_addr), 64'd0);
    check("async_wdata", 64'(zbt_write_data), 64'd0);
    check("async_rdata", 64'(rd_data), 64'd0);
    check("async_rvalid", 64'(rd_valid), 64'd0);
    check("async_count", 64'(point_count), 64'd0);
    step(); step();
    reset = 1'b0;
    repeat (4) step();

    // Reset between two read grants and their data return.
    n0 = n_valid;
    rd_req = 1'b1; rd_addr = AW'(32'd1);
    step();
    check("rr1_ack", 64'(got_r), 64'd1);
    rd_addr = AW'(32'd2);
    step();
    check("rr2_ack", 64'(got_r), 64'd1);
    rd_req = 1'b0;
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    repeat (6) step();
    check("no_valid_after_reset", 64'(n_valid - n0), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
